// File: rtl/br_pkg.sv
// Shared constants for the register-bank write-back path.
//   DATA_W   : register data width
//   ADDR_W   : register address width
//   NREG     : number of registers (2**ADDR_W)
//   REQ_ALU  : requester index of the ALU result
//   REQ_LOAD : requester index of the load data
package br_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREG     = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

endpackage

// File: rtl/control_escritura_br_arb_rr2.sv
// Two-way round-robin arbiter with a single-bit priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid[1:0] : request valids (index REQ_ALU / REQ_LOAD)
//   grant[1:0] : one-hot grant, combinational from valid and prio
//   prio       : requester favoured on the next contended cycle
// The pointer only moves when both requesters contend; a lone requester
// is granted without disturbing the fairness order.
module arb_rr2
  import br_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       prio
);

  logic prio_nxt;

  always_comb begin
    grant    = '0;
    prio_nxt = prio;
    case (valid)
      2'b01:   grant[REQ_ALU]  = 1'b1;
      2'b10:   grant[REQ_LOAD] = 1'b1;
      2'b11: begin
        grant[prio] = 1'b1;
        prio_nxt    = ~prio;
      end
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio <= 1'b0;
    else        prio <= prio_nxt;
  end

endmodule

// File: rtl/control_escritura_br.sv
// Write-back controller for the register bank.
// Arbitrates the bank's single write port between the ALU result
// (requester 0) and load data (requester 1), keeps a scoreboard of
// destinations still awaiting their value, and flags read hazards.
//   reserve_valid/addr        : issue claims a destination register
//   reqN_valid/addr/data      : write-back requests, reqN_ready accepts
//   wa, data_in, we           : registered bank write port
//   ra_A, ra_B                : bank read addresses being monitored
//   stall                     : a read address hits a pending register
//   busy                      : scoreboard, one bit per register
//   err                       : sticky, write to an unreserved register
module control_escritura_br #(
  parameter int DATA_W = br_pkg::DATA_W,
  parameter int ADDR_W = br_pkg::ADDR_W,
  parameter int NREG   = br_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] data_in,
  output logic              we,
  input  logic [ADDR_W-1:0] ra_A,
  input  logic [ADDR_W-1:0] ra_B,
  output logic              stall,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  import br_pkg::*;

  logic [1:0]        grant;
  logic              prio;
  logic              grant_any;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [NREG-1:0]   busy_nxt;
  logic              err_nxt;

  arb_rr2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .grant (grant),
    .prio  (prio)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_LOAD];
  assign grant_any  = |grant;

  always_comb begin
    g_addr = req0_addr;
    g_data = req0_data;
    if (grant[REQ_LOAD]) begin
      g_addr = req1_addr;
      g_data = req1_data;
    end
  end

  // Write port: a grant to register 0 still completes the handshake but
  // never raises we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we      <= 1'b0;
      wa      <= '0;
      data_in <= '0;
    end else if (grant_any) begin
      we      <= (g_addr != '0);
      wa      <= g_addr;
      data_in <= g_data;
    end else begin
      we      <= 1'b0;
    end
  end

  // Clear first, then set: a reservation in the same cycle as the write
  // of the previous value for that register keeps it pending.
  always_comb begin
    busy_nxt = busy;
    if (grant_any)     busy_nxt[g_addr]       = 1'b0;
    if (reserve_valid) busy_nxt[reserve_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    err_nxt = err;
    if (grant_any && (g_addr != '0) && !busy[g_addr]) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      err  <= err_nxt;
    end
  end

  // The busy bit drops as the write is registered, so the cycle in which
  // the bank is actually written is covered by comparing against wa.
  assign stall = busy[ra_A] | busy[ra_B] |
                 (we && (wa != '0) && ((wa == ra_A) || (wa == ra_B)));

  prio_flips_on_contention : assert property (
    @(posedge clk) disable iff (!rst_n)
    (req0_valid && req1_valid) |=> (prio != $past(prio))
  );

endmodule

// File: doc/control_escritura_br.md
# control_escritura_br

Write-back controller for the 32×32 register bank. It arbitrates the bank's single write port between two write-back requesters: requester 0 is the ALU result and requester 1 is the load data. It tracks pending destinations in a 32-bit scoreboard and raises a stall when either read address targets a register whose value is not yet written. It sits between the decode/issue logic and the bank's `wa`/`data_in`/`we` inputs.

## Interface
Parameters:
- `DATA_W`, 32, data width.
- `ADDR_W`, 5, register address width.
- `NREG`, 32, register count (2**ADDR_W).

Ports:
- `clk`, in, 1, single clock, rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `reserve_valid`, in, 1, issue stage claims a destination this cycle.
- `reserve_addr`, in, ADDR_W, claimed destination.
- `req0_valid`, in, 1, ALU write-back request.
- `req0_addr`, in, ADDR_W, ALU destination.
- `req0_data`, in, DATA_W, ALU result.
- `req0_ready`, out, 1, ALU request accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as the requester 0 ports, for load data.
- `wa`, out, ADDR_W, bank write address.
- `data_in`, out, DATA_W, bank write data.
- `we`, out, 1, bank write enable.
- `ra_A`, in, ADDR_W, bank read address A (monitored).
- `ra_B`, in, ADDR_W, bank read address B (monitored).
- `stall`, out, 1, read hazard; issue must hold.
- `busy`, out, NREG, scoreboard vector.
- `err`, out, 1, sticky protocol error.

## Operation
- **Handshake.** A transfer happens when `reqN_valid && reqN_ready`. `ready` is combinational from the valids and the priority pointer. A requester holds its valid, addr and data stable until accepted.
- **Arbitration.** Round-robin with a 1-bit pointer `prio`, reset to 0.
  - Only one requester valid: it is granted.
  - Both valid: `req[prio]` is granted and `prio` flips.
  - A single-valid grant leaves `prio` unchanged.
  - At most one grant per cycle.
- **Write port.** `we`, `wa` and `data_in` are registered from the granted request. With no grant, `we` is 0 and `wa`/`data_in` hold their last values.
  - A granted request with addr 0 completes the handshake, but `we` stays 0 (register 0 is never written).
- **Scoreboard.**
  - `busy[reserve_addr]` is set on `reserve_valid` when the address is nonzero.
  - `busy[addr]` is cleared on the edge that registers a grant for `addr`.
  - Set and clear of the same address in one cycle: set wins, because a new reservation supersedes the old one.
  - `busy[0]` is always 0.
- **Stall.** `stall = busy[ra_A] | busy[ra_B] | (we && wa != 0 && (wa == ra_A || wa == ra_B))`. The last term covers the cycle in which the bank is being written.
- **Error.** `err` is set when a grant targets a nonzero address whose busy bit is 0. It stays set until reset.

## Timing
- Reset (asynchronous, `rst_n` = 0): `we` = 0, `wa` = 0, `data_in` = 0, `busy` = 0, `prio` = 0, `err` = 0. `stall` then evaluates to 0.
- Latency: a grant in cycle N gives `we`/`wa`/`data_in` valid in cycle N+1. The busy bit is low from N+1.
- Throughput: one write per cycle. The losing requester waits at most one cycle when both are valid continuously.
- Reset asserted mid-transfer drops any pending grant. The requester must re-present after reset.

## Structure
- A shared package `br_pkg` holds `DATA_W`, `ADDR_W`, `NREG` and the requester index constants `REQ_ALU` = 0 and `REQ_LOAD` = 1.
- One sub-module, `arb_rr2`: a 2-way round-robin arbiter (inputs: valids; outputs: grant vector and the `prio` register).
- Scoreboard, write-port register and stall logic stay in the top module.

## Test plan
- Reset with all inputs active, then release → all outputs 0; first grant goes to req0 when both are valid.
- Reserve r5, then req0 with addr 5, data 0xDEADBEEF, next cycle → `req0_ready` = 1; next cycle `we` = 1, `wa` = 5, `data_in` = 0xDEADBEEF, `busy[5]` = 0.
- Reserve r3 and r4; req0 (r3) and req1 (r4) held valid together → grants in the order req0, req1. Repeat the pair → order req1, req0.
- `busy[7]` = 1 with `ra_A` = 7 → `stall` = 1 until the cycle after the write completes. With `ra_B` = 7 in the `we` cycle → `stall` = 1, and `stall` = 0 the following cycle.
- Req1 writes r9, which was never reserved → `err` = 1 and stays 1. Write to r0 → handshake completes, `we` = 0.
- `reserve_valid` for r6 in the same cycle as a grant to r6 → `busy[6]` remains 1.
